// File: rtl/cdc_event_sync.sv
// ============================================================================
// Module   : cdc_event_sync
// Brief    : Multi-channel asynchronous event synchroniser for the clk_200m
//            domain: edge pulse, stretched pulse, sticky flag, event counter.
//            Optional debounce stage enabled by defining CDC_EVT_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_event_sync #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int STRETCH_LEN = 16,
    parameter int CNT_W       = 16,
    parameter int FILT_LEN    = 4
) (
    input  logic                    clk_200m,
    input  logic                    rstn,
    input  logic [NUM_CH-1:0]       async_in_i,
    input  logic [2*NUM_CH-1:0]     edge_mode_i,
    input  logic [NUM_CH-1:0]       sticky_clr_i,
    input  logic                    cnt_clr_i,
    output logic                    armed_o,
    output logic [NUM_CH-1:0]       level_out_o,
    output logic [NUM_CH-1:0]       evt_pulse_o,
    output logic [NUM_CH-1:0]       evt_stretch_o,
    output logic [NUM_CH-1:0]       evt_sticky_o,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt_o
);

`ifdef CDC_EVT_DEBOUNCE_EN
    localparam bit c_deb_en = 1'b1;
`else
    localparam bit c_deb_en = 1'b0;
`endif

    // Detection stays disabled until the pipeline holds post-reset samples only.
    localparam int c_arm_cyc = SYNC_STAGES + 1 + (c_deb_en ? FILT_LEN : 0);
    localparam int c_aw      = $clog2(c_arm_cyc + 1);

    localparam logic [1:0] c_mode_rise = 2'b00;
    localparam logic [1:0] c_mode_fall = 2'b01;
    localparam logic [1:0] c_mode_both = 2'b10;

    logic [c_aw-1:0] arm_cnt_q, arm_cnt_d;
    logic            armed_q, armed_d;

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            arm_cnt_d = arm_cnt_q + 1'b1;
            if (arm_cnt_q == c_aw'(c_arm_cyc - 1)) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
        end
    end

    assign armed_o = armed_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_lvl;
        logic                   lvl;
        logic                   prev_q;
        logic                   evt_d;
        logic                   pulse_q;
        logic [7:0]             str_q, str_d;
        logic                   sticky_q, sticky_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;

        always_ff @(posedge clk_200m) begin
            if (!rstn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], async_in_i[i]};
            end
        end

        assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef CDC_EVT_DEBOUNCE_EN
        localparam int c_fw = $clog2(FILT_LEN + 1);
        logic            filt_q, filt_d;
        logic [c_fw-1:0] fcnt_q, fcnt_d;

        // Any sample matching the filtered level restarts the stability count.
        always_comb begin
            filt_d = filt_q;
            fcnt_d = '0;
            if (sync_lvl != filt_q) begin
                if (fcnt_q == c_fw'(FILT_LEN - 1)) begin
                    filt_d = sync_lvl;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_200m) begin
            if (!rstn) begin
                filt_q <= 1'b0;
                fcnt_q <= '0;
            end else begin
                filt_q <= filt_d;
                fcnt_q <= fcnt_d;
            end
        end

        assign lvl = filt_q;
`else
        assign lvl = sync_lvl;
`endif

        always_comb begin
            evt_d = 1'b0;
            unique case (edge_mode_i[2*i +: 2])
                c_mode_rise: evt_d = lvl & ~prev_q;
                c_mode_fall: evt_d = ~lvl & prev_q;
                c_mode_both: evt_d = lvl ^ prev_q;
                default:     evt_d = 1'b0;
            endcase
            evt_d = evt_d & armed_q;
        end

        // A new event reloads the window, so overlapping events merge.
        always_comb begin
            str_d = str_q;
            if (evt_d) begin
                str_d = 8'(STRETCH_LEN);
            end else if (str_q != 8'd0) begin
                str_d = str_q - 8'd1;
            end
        end

        assign sticky_d = evt_d | (sticky_q & ~sticky_clr_i[i]);

        always_comb begin
            cnt_d = cnt_q;
            if (evt_d) begin
                if (cnt_clr_i) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (cnt_clr_i) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk_200m) begin
            if (!rstn) begin
                prev_q   <= 1'b0;
                pulse_q  <= 1'b0;
                str_q    <= 8'd0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                prev_q   <= lvl;
                pulse_q  <= evt_d;
                str_q    <= str_d;
                sticky_q <= sticky_d;
                cnt_q    <= cnt_d;
            end
        end

        assign level_out_o[i]               = prev_q;
        assign evt_pulse_o[i]               = pulse_q;
        assign evt_stretch_o[i]             = (str_q != 8'd0);
        assign evt_sticky_o[i]              = sticky_q;
        assign evt_cnt_o[i*CNT_W +: CNT_W]  = cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_cdc_event_sync.sv
// ============================================================================
// Module   : tb_cdc_event_sync
// Brief    : Directed self-checking bench for cdc_event_sync (NUM_CH=4,
//            CNT_W=4); expectations follow CDC_EVT_DEBOUNCE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cdc_event_sync;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
`ifdef CDC_EVT_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic                    clk_200m;
    logic                    rstn;
    logic [NUM_CH-1:0]       async_in;
    logic [2*NUM_CH-1:0]     edge_mode;
    logic [NUM_CH-1:0]       sticky_clr;
    logic                    cnt_clr;
    logic                    armed;
    logic [NUM_CH-1:0]       level_out;
    logic [NUM_CH-1:0]       evt_pulse;
    logic [NUM_CH-1:0]       evt_stretch;
    logic [NUM_CH-1:0]       evt_sticky;
    logic [NUM_CH*CNT_W-1:0] evt_cnt;

    int n_pass  = 0;
    int n_total = 0;

    cdc_event_sync #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (3),
        .STRETCH_LEN (16),
        .CNT_W       (CNT_W),
        .FILT_LEN    (4)
    ) dut (
        .clk_200m      (clk_200m),
        .rstn          (rstn),
        .async_in_i    (async_in),
        .edge_mode_i   (edge_mode),
        .sticky_clr_i  (sticky_clr),
        .cnt_clr_i     (cnt_clr),
        .armed_o       (armed),
        .level_out_o   (level_out),
        .evt_pulse_o   (evt_pulse),
        .evt_stretch_o (evt_stretch),
        .evt_sticky_o  (evt_sticky),
        .evt_cnt_o     (evt_cnt)
    );

    initial clk_200m = 1'b0;
    always #2.5 clk_200m = ~clk_200m;

    task automatic step();
        @(posedge clk_200m);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(evt_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    initial begin
        int n;
        logic [3:0] exp_p;

        rstn       = 1'b0;
        async_in   = 4'hF;
        edge_mode  = 8'h00;
        sticky_clr = 4'h0;
        cnt_clr    = 1'b0;
        steps(3);
        chk("rst_armed",   32'(armed),       32'h0);
        chk("rst_level",   32'(level_out),   32'h0);
        chk("rst_pulse",   32'(evt_pulse),   32'h0);
        chk("rst_stretch", 32'(evt_stretch), 32'h0);
        chk("rst_sticky",  32'(evt_sticky),  32'h0);
        chk("rst_cnt",     32'(evt_cnt),     32'h0);

        // Inputs already high at release must not produce events.
        rstn = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            chk("arm_armed", 32'(armed), (k >= LAT) ? 32'h1 : 32'h0);
            chk("arm_pulse", 32'(evt_pulse), 32'h0);
        end
        chk("arm_level",  32'(level_out),  32'hF);
        chk("arm_cnt",    32'(evt_cnt),    32'h0);
        chk("arm_sticky", 32'(evt_sticky), 32'h0);

        // Channel 0 single rise.
        async_in[0] = 1'b0;
        for (int s = 1; s <= LAT + 4; s++) begin
            step();
            chk("ch0_fall_quiet", 32'(evt_pulse), 32'h0);
        end
        async_in[0] = 1'b1;
        for (int s = 1; s <= LAT + 18; s++) begin
            step();
            chk("ch0_pulse",   32'(evt_pulse), (s == LAT) ? 32'h1 : 32'h0);
            chk("ch0_stretch", 32'(evt_stretch[0]), (s >= LAT && s < LAT + 16) ? 32'h1 : 32'h0);
        end
        chk("ch0_sticky", 32'(evt_sticky), 32'h1);
        chk("ch0_cnt",    cnt_of(0),       32'h1);

        // Channel 1 both-edge mode, four toggles 5 cycles apart.
        edge_mode[3:2] = 2'b10;
        for (int s = 1; s <= LAT + 35; s++) begin
            if ((s - 1) % 5 == 0 && (s - 1) / 5 < 4) async_in[1] = ~async_in[1];
            step();
            exp_p = (s >= LAT && (s - LAT) % 5 == 0 && (s - LAT) / 5 < 4) ? 4'b0010 : 4'b0000;
            chk("ch1_pulse",   32'(evt_pulse), 32'(exp_p));
            chk("ch1_stretch", 32'(evt_stretch[1]), (s >= LAT && s < LAT + 31) ? 32'h1 : 32'h0);
        end
        chk("ch1_cnt",    cnt_of(1),       32'h4);
        chk("ch1_sticky", 32'(evt_sticky), 32'h3);

        // Channel 2 disabled: level follows, no events.
        edge_mode[5:4] = 2'b11;
        for (int s = 1; s <= 50 + LAT + 2; s++) begin
            if ((s - 1) % 5 == 0 && (s - 1) / 5 < 10) async_in[2] = ~async_in[2];
            step();
            n = 0;
            for (int j = 0; j < 10; j++) if (5 * j + LAT <= s) n++;
            chk("ch2_pulse", 32'(evt_pulse), 32'h0);
            chk("ch2_level", 32'(level_out[2]), (n % 2 == 1) ? 32'h0 : 32'h1);
        end
        chk("ch2_cnt",    cnt_of(2),          32'h0);
        chk("ch2_sticky", 32'(evt_sticky[2]), 32'h0);

        // Channel 3: 20 rises saturate a 4-bit counter.
        for (int e = 0; e < 20; e++) begin
            async_in[3] = 1'b0;
            steps(5);
            async_in[3] = 1'b1;
            steps(5);
        end
        steps(LAT);
        chk("ch3_sat",    cnt_of(3),          32'hF);
        chk("ch3_sticky", 32'(evt_sticky[3]), 32'h1);

        async_in[3] = 1'b0;
        steps(LAT + 2);
        async_in[3] = 1'b1;
        steps(LAT - 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_evt_pulse", 32'(evt_pulse), 32'h8);
        chk("clr_evt_cnt3",  cnt_of(3),      32'h1);
        chk("clr_cnt0",      cnt_of(0),      32'h0);
        chk("clr_cnt1",      cnt_of(1),      32'h0);

        sticky_clr = 4'b1000;
        step();
        sticky_clr = 4'b0000;
        chk("sticky_clr_alone", 32'(evt_sticky), 32'h3);

        async_in[3] = 1'b0;
        steps(LAT + 2);
        async_in[3] = 1'b1;
        steps(LAT - 1);
        sticky_clr = 4'b1000;
        step();
        sticky_clr = 4'b0000;
        chk("sticky_set_wins", 32'(evt_sticky), 32'hB);
        chk("ch3_cnt_after",   cnt_of(3),       32'h2);

        // Channel 0: 2-cycle glitch, then 6-cycle-wide high.
        async_in[0] = 1'b0;
        steps(LAT + 2);
        for (int s = 1; s <= 20; s++) begin
            if (s == 1) async_in[0] = 1'b1;
            if (s == 3) async_in[0] = 1'b0;
            step();
`ifdef CDC_EVT_DEBOUNCE_EN
            chk("glitch_pulse", 32'(evt_pulse), 32'h0);
`else
            chk("glitch_pulse", 32'(evt_pulse), (s == LAT) ? 32'h1 : 32'h0);
`endif
        end
        for (int s = 1; s <= 20; s++) begin
            if (s == 1) async_in[0] = 1'b1;
            if (s == 7) async_in[0] = 1'b0;
            step();
            chk("wide_pulse", 32'(evt_pulse), (s == LAT) ? 32'h1 : 32'h0);
        end

        // Channel 0 fall mode, then reset in the middle of the stretch.
        edge_mode[1:0] = 2'b01;
        for (int s = 1; s <= LAT + 6; s++) begin
            if (s == 1) async_in[0] = 1'b1;
            step();
            chk("fallmode_rise_quiet", 32'(evt_pulse), 32'h0);
        end
        for (int s = 1; s <= LAT + 3; s++) begin
            if (s == 1) async_in[0] = 1'b0;
            step();
            chk("fallmode_pulse", 32'(evt_pulse), (s == LAT) ? 32'h1 : 32'h0);
        end
        chk("mid_stretch", 32'(evt_stretch[0]), 32'h1);

        rstn = 1'b0;
        step();
        chk("rst2_armed",   32'(armed),       32'h0);
        chk("rst2_level",   32'(level_out),   32'h0);
        chk("rst2_pulse",   32'(evt_pulse),   32'h0);
        chk("rst2_stretch", 32'(evt_stretch), 32'h0);
        chk("rst2_sticky",  32'(evt_sticky),  32'h0);
        chk("rst2_cnt",     32'(evt_cnt),     32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdc_event_sync.md
Name: cdc_event_sync

Overview:
- Multi-channel event synchroniser in the clk_200m domain. It brings asynchronous flags into clk_200m, for example udp_send_data_ready and valid strobes from rgmii_clk.
- Per channel it produces a single-cycle edge pulse, a pulse stretched to a fixed length, a sticky status bit and a saturating event counter.
- It replaces hand-built synchroniser chains and OR-stretchers in top-level glue logic.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- SYNC_STAGES, 3, synchroniser flops per channel (2..4).
- STRETCH_LEN, 16, evt_stretch high time in clk_200m cycles (1..255).
- CNT_W, 16, width of each per-channel event counter.
- FILT_LEN, 4, stable-cycle count for the debounce filter (used only with CDC_EVT_DEBOUNCE_EN).

Ports:
- clk_200m  in  1  block clock.
- rstn  in  1  reset, synchronous, active-low.
- async_in  in  NUM_CH  asynchronous input flags.
- edge_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 rise, 01 fall, 10 both, 11 disabled.
- sticky_clr  in  NUM_CH  per-channel sticky clear, one-cycle pulse.
- cnt_clr  in  1  clears all counters.
- armed  out  1  edge detection enabled after reset.
- level_out  out  NUM_CH  synchronised (and filtered, if enabled) level.
- evt_pulse  out  NUM_CH  one-cycle event strobe.
- evt_stretch  out  NUM_CH  stretched event.
- evt_sticky  out  NUM_CH  latched event flag.
- evt_cnt  out  NUM_CH*CNT_W  counters, channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (rstn=0 at a clk_200m edge) clears to 0:
  - sync chains, prev-level registers, stretch counters and arm counter;
  - all outputs: armed, level_out, evt_pulse, evt_stretch, evt_sticky, evt_cnt.
- Reset asserted mid-stretch or mid-count aborts immediately; no pulse survives reset.
- Synchroniser:
  - async_in[i] passes through SYNC_STAGES flops to give sync_lvl[i].
  - level_out[i] is registered sync_lvl[i], which is also the prev level.
- Arming:
  - An arm counter counts SYNC_STAGES+1 cycles after rstn deasserts; armed then rises and stays high.
  - While armed=0, no edges are detected, so an input already high at reset release gives no event.
- Edge detect, evaluated combinationally from sync_lvl and prev:
  - rise = sync & ~prev; fall = ~sync & prev.
  - The event is selected by edge_mode; mode 11 never fires.
- Latency: with the input changing before clock edge 1, evt_pulse is high in the cycle following edge SYNC_STAGES+1, i.e. edge 4 at default.
- evt_pulse: registered, exactly one cycle per detected edge. Back-to-back edges in "both" mode give pulses on consecutive detections.
- evt_stretch:
  - Rises with evt_pulse.
  - An 8-bit down-counter loads STRETCH_LEN and holds the output high for exactly STRETCH_LEN cycles.
  - A new event during a stretch reloads the counter, extending the window; there is no gap and no double count in the stretch.
- evt_sticky:
  - Set by an event, cleared by sticky_clr.
  - Set and clear in the same cycle: set wins.
- evt_cnt:
  - +1 per event, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clr clears all counters.
  - cnt_clr together with an event on channel i: counter i becomes 1.
- edge_mode changes take effect on the next cycle. A mode change by itself never produces an event.
- Channels are fully independent; there are no cross-channel interactions.

Optional Feature:
- CDC_EVT_DEBOUNCE_EN defined:
  - Each channel adds a debounce stage after the synchroniser, using a stable-counter of width clog2(FILT_LEN+1).
  - The filtered level updates only after sync_lvl differs from it for FILT_LEN consecutive cycles.
  - Any bounce restarts the count.
  - Edge detection and level_out use the filtered level, adding FILT_LEN cycles of latency.
  - The arm time becomes SYNC_STAGES+FILT_LEN+1 cycles.
- Not defined: the filtered level equals sync_lvl and the debounce logic is absent.

Test Plan:
- Reset with async_in=4'b1111, all modes 00 -> armed rises 4 cycles after rstn release; evt_pulse and evt_cnt stay 0; level_out=4'hF.
- Channel 0 rises once, mode 00 -> evt_pulse[0] high 1 cycle at latency 4; evt_stretch[0] high 16 cycles; evt_sticky[0]=1; evt_cnt ch0=1.
- Channel 1 mode 10, toggled every 5 cycles for 4 edges -> 4 pulses; evt_cnt ch1=4; evt_stretch[1] continuous until 16 cycles after the last pulse.
- Channel 2 mode 11, toggled 10 times -> no pulses, count 0; level_out[2] still follows the input.
- Counter saturation with CNT_W=4: 20 rising edges on ch3 -> evt_cnt ch3=15. Then cnt_clr coincident with an edge -> ch3=1. Then sticky_clr coincident with an edge -> evt_sticky[3] stays 1.
- CDC_EVT_DEBOUNCE_EN defined, FILT_LEN=4:
  - 2-cycle glitch on ch0 -> no event.
  - 6-cycle-wide high -> one pulse at latency 8.
  - rstn pulled low mid-stretch -> all outputs 0 the next cycle.
